// File: rtl/frame_writer.sv
// Capture side of the 1-bpp frame store: thresholds streamed RGB pixels, packs 8 per byte
// (pixel p -> byte p[18:3], bit 7-p[2:0]). Optional FRAME_WRITER_DITHER_EN adds 2x2 Bayer dither.
module frame_writer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic        i_vga_clk,
  input  logic        rstn,
  input  logic        i_arm,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sof,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_wr_en,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_mem_ready,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_sof_err
);

  localparam logic [18:0] LastPix = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [7:0]  Thresh  = 8'(THRESHOLD);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d, eff_cnt;
  logic [7:0]  pack_q, pack_d, eff_pack, packed_byte;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        last_q, last_d, done_q, done_d, sof_err_q, sof_err_d;
  logic        xfer, take, restart, pix_bit;
  logic [9:0]  luma_sum;
  logic [7:0]  thr_eff;

  assign o_ready = !(wr_en_q && !i_mem_ready);
  assign xfer    = i_valid && o_ready;
  assign take    = xfer && ((state_q == StCapture) || (state_q == StArmed && i_sof));
  // A qualifying sof (or the first pixel out of ARMED) starts pixel 0 with an empty pack.
  assign restart  = take && i_sof && ((state_q == StArmed) || (cnt_q != '0));
  assign eff_cnt  = restart ? '0 : cnt_q;
  assign eff_pack = restart ? '0 : pack_q;

  assign luma_sum = {2'b00, i_red} + {1'b0, i_green, 1'b0} + {2'b00, i_blue};
  // (sum >> 2) >= thr is the same as sum >= thr * 4, which keeps the low bits meaningful.
  assign pix_bit  = luma_sum >= {thr_eff, 2'b00};

`ifdef FRAME_WRITER_DITHER_EN
  logic [18:0]       col_q, col_d, col_eff;
  logic              line_q, line_d, line_eff;
  logic signed [9:0] bayer, thr_s;

  always_comb begin
    col_eff  = restart ? '0 : col_q;
    line_eff = restart ? 1'b0 : line_q;
    unique case ({line_eff, col_eff[0]})
      2'b00:   bayer = -10'sd48;
      2'b01:   bayer = 10'sd16;
      2'b10:   bayer = 10'sd48;
      default: bayer = -10'sd16;
    endcase
    thr_s = $signed({2'b00, Thresh}) + bayer;
    if (thr_s < 10'sd0) begin
      thr_eff = 8'h00;
    end else if (thr_s > 10'sd255) begin
      thr_eff = 8'hFF;
    end else begin
      thr_eff = thr_s[7:0];
    end
    col_d  = col_q;
    line_d = line_q;
    if (take) begin
      if (eff_cnt == LastPix) begin
        col_d  = '0;
        line_d = 1'b0;
      end else if (col_eff == 19'(H_ACTIVE - 1)) begin
        col_d  = '0;
        line_d = ~line_eff;
      end else begin
        col_d  = col_eff + 19'd1;
        line_d = line_eff;
      end
    end
  end

  always_ff @(posedge i_vga_clk or negedge rstn) begin
    if (!rstn) begin
      col_q  <= '0;
      line_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end
`else
  assign thr_eff = Thresh;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    last_d      = last_q;
    done_d      = 1'b0;
    sof_err_d   = take && i_sof && (state_q == StCapture) && (cnt_q != '0);
    packed_byte = eff_pack;
    packed_byte[3'd7 - eff_cnt[2:0]] = pix_bit;

    if (wr_en_q && i_mem_ready) begin
      wr_en_d = 1'b0;
      last_d  = 1'b0;
      done_d  = last_q;
    end

    unique case (state_q)
      StIdle:             if (i_arm) state_d = StArmed;
      StArmed, StCapture: ;
      default:            state_d = StIdle;
    endcase

    if (take) begin
      if (eff_cnt[2:0] == 3'd7) begin
        wr_en_d   = 1'b1;
        wr_addr_d = eff_cnt[18:3];
        wr_data_d = packed_byte;
        last_d    = (eff_cnt == LastPix);
        pack_d    = '0;
      end else begin
        pack_d = packed_byte;
      end
      if (eff_cnt == LastPix) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StCapture;
        cnt_d   = eff_cnt + 19'd1;
      end
    end
  end

  always_ff @(posedge i_vga_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      done_q    <= done_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = done_q;
  assign o_sof_err    = sof_err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on a 16x4 frame: a pixel-level model predicts every write,
// handshake and pulse each cycle; literal byte/count expectations pin the model.
module tb_frame_writer;

  localparam int H = 16;
  localparam int V = 4;
  localparam int N = H * V;
  localparam int NB = N / 8;

  logic        clk, rstn, i_arm, i_valid, o_ready, i_sof;
  logic [7:0]  i_red, i_green, i_blue;
  logic        o_wr_en, i_mem_ready, o_busy, o_frame_done, o_sof_err;
  logic [15:0] o_wr_addr;
  logic [7:0]  o_wr_data;

  frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(128)) dut (
    .i_vga_clk(clk), .rstn(rstn), .i_arm(i_arm), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .i_mem_ready(i_mem_ready), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_sof_err(o_sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int addr; int data; bit last;} wr_t;
  wr_t expq[$];
  int  checks = 0, passes = 0;
  int  mstate = 0, mcnt = 0, mpack = 0;
  bit  done_exp = 0, err_exp = 0;
  int  acc_writes = 0, done_cnt = 0, err_cnt = 0;
  int  img[0:NB-1];
  bit  stall_req = 0;
  int  stall_left = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp,
                  $time);
  endtask

  function automatic bit model_bit(input int r, input int g, input int b, input int p);
    int luma, thr;
    luma = (r + 2 * g + b) / 4;
    thr  = 128;
`ifdef FRAME_WRITER_DITHER_EN
    if ((p / H) % 2 == 0) thr += ((p % H) % 2 == 0) ? -48 : 16;
    else                  thr += ((p % H) % 2 == 0) ? 48 : -16;
    if (thr > 255) thr = 255;
    if (thr < 0) thr = 0;
`endif
    return luma >= thr;
  endfunction

  // Patterns: 0 white, 1 white/black alternate, 2 four white four black, 3 threshold edges.
  function automatic logic [23:0] pix(input int pat, input int i);
    logic [23:0] w, k, t[0:7];
    w = 24'hFFFFFF;
    k = 24'h000000;
    t = '{24'h808080, 24'h7F7F7F, 24'hFF00FF, 24'h808080,
          24'h808080, 24'h7F7F7F, 24'h7F7F7F, 24'h808080};
    case (pat)
      1:       return (i % 2 == 0) ? w : k;
      2:       return (i % 8 < 4) ? w : k;
      3:       return (i < 8) ? t[i] : w;
      default: return w;
    endcase
  endfunction

  task automatic compare_cycle();
    bit exp_ready, go;
    if (!rstn) begin
      expq.delete();
      mstate = 0; mcnt = 0; mpack = 0; done_exp = 0; err_exp = 0;
      chk("rst_wr_en", o_wr_en, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_sof_err", o_sof_err, 0);
      chk("rst_addr", o_wr_addr, 0);
      chk("rst_data", o_wr_data, 0);
      return;
    end
    exp_ready = !(expq.size() > 0 && !i_mem_ready);
    chk("ready", o_ready, exp_ready);
    chk("busy", o_busy, mstate != 0);
    chk("frame_done", o_frame_done, done_exp);
    chk("sof_err", o_sof_err, err_exp);
    chk("wr_en", o_wr_en, expq.size() > 0);
    if (o_frame_done) done_cnt++;
    if (o_sof_err) err_cnt++;
    done_exp = 0;
    err_exp  = 0;
    if (expq.size() > 0) begin
      chk("wr_addr", o_wr_addr, expq[0].addr);
      chk("wr_data", o_wr_data, expq[0].data);
      if (i_mem_ready) begin
        done_exp = expq[0].last;
        if (o_wr_addr < NB) img[o_wr_addr] = o_wr_data;
        acc_writes++;
        void'(expq.pop_front());
      end
    end
    if (mstate == 0) begin
      if (i_arm) mstate = 1;
    end else if (i_valid && exp_ready) begin
      go = 0;
      if (mstate == 1) begin
        if (i_sof) begin
          go = 1; mcnt = 0; mpack = 0; mstate = 2;
        end
      end else begin
        go = 1;
        if (i_sof && mcnt != 0) begin
          err_exp = 1; mcnt = 0; mpack = 0;
        end
      end
      if (go) begin
        if (model_bit(i_red, i_green, i_blue, mcnt)) mpack |= 1 << (7 - mcnt % 8);
        if (mcnt % 8 == 7) begin
          expq.push_back('{addr: mcnt / 8, data: mpack, last: (mcnt == N - 1)});
          mpack = 0;
        end
        mcnt++;
        if (mcnt == N) begin
          mstate = 0; mcnt = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] rgb, input bit sof);
    bit rd, ok;
    {i_red, i_green, i_blue} = rgb;
    i_sof   = sof;
    i_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rd = o_ready;
      step();
      if (rd) begin
        ok = 1;
        break;
      end
    end
    chk("pix_accept", ok, 1);
  endtask

  task automatic send_stream(input int pat, input int n, input int sof2);
    for (int i = 0; i < n; i++) send_pix(pix(pat, i), (i == 0) || (i == sof2));
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!o_wr_en && !o_busy) begin
        idle = 1;
        break;
      end
    end
    chk("drain_idle", idle, 1);
    repeat (3) step();
  endtask

  int w0, d0, e0;

  initial begin
    rstn = 1'b1; i_arm = 0; i_valid = 0; i_sof = 0; i_red = 0; i_green = 0; i_blue = 0;
    i_mem_ready = 1'b1;
    for (int i = 0; i < NB; i++) img[i] = -1;
    #2 rstn = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      forever begin
        step();
        if (stall_left > 0) begin
          i_mem_ready = 1'b0;
          stall_left--;
        end else if (stall_req && o_wr_en) begin
          stall_req   = 0;
          i_mem_ready = 1'b0;
          stall_left  = 4;
        end else begin
          i_mem_ready = 1'b1;
        end
      end
    join_none
    repeat (3) step();
    rstn = 1'b1;
    step();

    // All white: NB writes of 0xFF, one done pulse, busy back to 0.
    w0 = acc_writes; d0 = done_cnt;
    arm();
    send_stream(0, N, -1);
    drain();
    chk("white_writes", acc_writes - w0, NB);
    chk("white_done", done_cnt - d0, 1);
    chk("white_byte0", img[0], 'hFF);
    chk("white_last", img[NB-1], 'hFF);
    chk("white_busy", o_busy, 0);

    arm();
    send_stream(1, N, -1);
    drain();
    chk("alt_byte3", img[3], 'hAA);

    arm();
    send_stream(2, N, -1);
    drain();
    chk("f0_byte0", img[0], 'hF0);

    arm();
    send_stream(3, N, -1);
    drain();
`ifndef FRAME_WRITER_DITHER_EN
    chk("thresh_byte0", img[0], 'h99);
`endif
    chk("thresh_byte1", img[1], 'hFF);

    // Memory stall of 5 cycles on the first write.
    w0 = acc_writes;
    stall_req = 1;
    arm();
    send_stream(1, N, -1);
    drain();
    chk("stall_writes", acc_writes - w0, NB);
    chk("stall_byte5", img[5], 'hAA);

    // Restart via sof at pixel 20: bytes 0,1 then a full frame.
    w0 = acc_writes; d0 = done_cnt; e0 = err_cnt;
    arm();
    send_stream(0, N + 20, 20);
    drain();
    chk("sof_err_pulses", err_cnt - e0, 1);
    chk("sof_writes", acc_writes - w0, 2 + NB);
    chk("sof_done", done_cnt - d0, 1);

    // Reset mid-frame, then stream without arm, then a fresh capture.
    arm();
    send_stream(0, 30, -1);
    step();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
    w0 = acc_writes;
    send_stream(0, N, -1);
    drain();
    chk("idle_writes", acc_writes - w0, 0);
    w0 = acc_writes; d0 = done_cnt;
    arm();
    send_stream(2, N, -1);
    drain();
    chk("rearm_writes", acc_writes - w0, NB);
    chk("rearm_byte0", img[0], 'hF0);
    chk("rearm_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Capture side of the 1-bit-per-pixel frame store. Accepts a streamed RGB pixel frame with valid/ready, thresholds each pixel to one bit, packs eight consecutive pixels into a byte and writes it to the image RAM at pixel-index/8. The bit layout matches the display read path: pixel index p lands in byte p[18:3], bit 7−p[2:0]. Capture is one-shot per arm request, so a frozen frame can be reloaded without stalling the video source.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame; H_ACTIVE*V_ACTIVE is a multiple of 8 and ≤ 2^19
- THRESHOLD, 128, 8-bit luma threshold; luma ≥ THRESHOLD → bit 1
- i_vga_clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- i_arm  in  1  one-cycle request to capture the next frame
- i_valid  in  1  pixel valid
- o_ready  out  1  pixel accept; transfer when i_valid && o_ready
- i_sof  in  1  qualifies the current pixel as pixel 0 of a frame; sampled only on transfer
- i_red, i_green, i_blue  in  8 each  pixel colour
- o_wr_en  out  1  RAM write request
- o_wr_addr  out  16  byte address
- o_wr_data  out  8  packed byte
- i_mem_ready  in  1  RAM accepts the write this cycle
- o_busy  out  1  state is ARMED or CAPTURE
- o_frame_done  out  1  one-cycle pulse, last byte of frame accepted by RAM
- o_sof_err  out  1  one-cycle pulse, i_sof seen mid-frame

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: o_ready=1, pixels consumed and discarded. i_arm → ARMED.
- ARMED: o_ready=1, pixels discarded until a transfer with i_sof=1. That pixel is pixel 0, and the state moves to CAPTURE. i_arm is ignored outside IDLE.
- CAPTURE: each transfer computes bit = luma ≥ THRESHOLD, where luma = (R + 2G + B) >> 2 with 10-bit intermediate and no overflow. The bit is stored at position 7−cnt[2:0] of the pack register, and the 19-bit pixel counter cnt increments.
- When cnt[2:0]==7 on a transfer:
  - load o_wr_data with the completed byte, including the current bit;
  - load o_wr_addr with cnt[18:3];
  - assert o_wr_en.
- o_wr_en, o_wr_addr and o_wr_data hold stable until i_mem_ready=1. o_wr_en drops on the cycle after acceptance unless a new byte is loaded on the same edge.
- o_ready = !(o_wr_en && !i_mem_ready) in every state. A pending write is never overwritten.
- Last pixel (cnt = H_ACTIVE*V_ACTIVE−1) transferred: the state goes to IDLE. o_frame_done pulses in the cycle after the final write is accepted by RAM.
- i_sof on a transfer in CAPTURE with cnt≠0:
  - o_sof_err pulses;
  - the partial pack register is discarded;
  - that pixel becomes pixel 0 of a fresh frame;
  - an already-pending write still completes.
- Reset, including mid-frame: state IDLE, cnt=0, pack register 0. All outputs 0 except o_ready=1. No partial byte is written.

## Timing
- Transfer-to-write latency: o_wr_en is visible in the cycle after the 8th pixel transfer.
- Sustained throughput: 1 pixel/clock while i_mem_ready=1.
- A frame of N pixels produces exactly N/8 writes at ascending addresses 0…N/8−1 with no gaps or repeats.
- o_frame_done is asserted in the cycle following the edge where the final write was accepted (o_wr_en && i_mem_ready).
- o_busy is registered and follows the state with 0-cycle lag.
- o_sof_err is registered and asserted in the cycle after the offending transfer.

## Configuration
- FRAME_WRITER_DITHER_EN defined: the effective threshold is THRESHOLD + bayer[y[0]][x[0]].
  - The 2×2 matrix is {−48, +16; +48, −16}, indexed by pixel column and line parity derived from cnt and H_ACTIVE.
  - The result saturates to 0…255.
  - A line counter and a column counter are added.
- Undefined: the fixed THRESHOLD compare, and no line or column counters exist.

## Test plan
- Reset, then i_arm, then a frame with i_sof on pixel 0, all pixels 0xFF/0xFF/0xFF, i_mem_ready=1 → expected response:
  - 38400 writes of 0xFF at addresses 0…38399;
  - o_frame_done pulses once, 1 cycle after the last write;
  - o_busy returns to 0.
- Alternating pixels white/black from pixel 0 → every byte is 0xAA. Pixels 0–7 = 1,1,1,1,0,0,0,0 → byte 0 = 0xF0.
- Threshold edge, dither off: R=G=B=128 → bit 1; R=G=B=127 → bit 0; R=255, G=0, B=255 (luma 127) → bit 0.
- i_mem_ready held low for 5 cycles during a write → expected response:
  - o_ready=0 throughout;
  - o_wr_addr and o_wr_data stable;
  - no pixel lost;
  - the byte count is still 38400.
- i_sof asserted at pixel 1000 mid-frame → o_sof_err pulses, writes restart at address 0, and the frame completes 307200 pixels later.
- rstn asserted at pixel 500, then i_arm with a new frame → no write is issued after reset, and the next capture starts at address 0. Pixels streamed in IDLE without i_arm → zero writes.
